// File: rtl/icache_mshr_ctrl.sv
// ----------------------------------------------------------------------------
// icache_mshr_ctrl
//   Non-blocking miss / prefetch controller for the instruction cache.
//   Tracks up to NUM_MSHR outstanding line loads by Imem tag and runs a
//   next-N-line prefetch stream of depth PF_DEPTH. Fill data is forwarded
//   to fetch in the cycle the fill arrives.
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   if_addr_i, if_flush_i  fetch PC and mispredict flush
//   cache_hit_i/data_i     cachemem lookup result for if_addr_i
//   cache_pf_hit_i         cachemem lookup result for pf_probe_addr_o
//   pf_probe_addr_o        line-aligned prefetch probe address
//   mem_response_i         Imem request acceptance tag (0 = rejected)
//   mem_tag_i, mem_data_i  Imem fill tag (0 = none) and data
//   mem_addr_o, mem_command_o  Imem request
//   wr_en_o/idx_o/tag_o    cachemem write port (fills)
//   if_vld_o, if_data_o    instruction line to fetch
//   outstanding_o          number of valid MSHR entries
// ----------------------------------------------------------------------------
module icache_mshr_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int IDX_W     = 5,
    parameter int NUM_MSHR  = 4,
    parameter int PF_DEPTH  = 2,
    parameter int MEM_TAG_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             if_addr_i,
    input  logic                          if_flush_i,
    input  logic                          cache_hit_i,
    input  logic [63:0]                   cache_data_i,
    input  logic                          cache_pf_hit_i,
    output logic [ADDR_W-1:0]             pf_probe_addr_o,
    input  logic [MEM_TAG_W-1:0]          mem_response_i,
    input  logic [MEM_TAG_W-1:0]          mem_tag_i,
    input  logic [63:0]                   mem_data_i,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [1:0]                    mem_command_o,
    output logic                          wr_en_o,
    output logic [IDX_W-1:0]              wr_idx_o,
    output logic [ADDR_W-3-IDX_W-1:0]     wr_tag_o,
    output logic                          if_vld_o,
    output logic [63:0]                   if_data_o,
    output logic [$clog2(NUM_MSHR+1)-1:0] outstanding_o
);

    localparam int LINE_W = ADDR_W - 3;
    localparam int CNT_W  = $clog2(NUM_MSHR + 1);
    localparam int MI_W   = $clog2(NUM_MSHR);
    // Wide enough to hold PF_DEPTH itself, and at least one bit when PF_DEPTH=0.
    localparam int PFC_W  = $clog2(PF_DEPTH + 2);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    // MSHR entries
    logic [NUM_MSHR-1:0]                vld_q,  vld_d;
    logic [NUM_MSHR-1:0][LINE_W-1:0]    line_q, line_d;
    logic [NUM_MSHR-1:0][MEM_TAG_W-1:0] mtag_q, mtag_d;

    // Prefetch stream and last demand line
    logic [LINE_W-1:0] pf_line_q, pf_line_d;
    logic [PFC_W-1:0]  pf_cnt_q,  pf_cnt_d;
    logic [LINE_W-1:0] dline_q,   dline_d;
    logic              dline_vld_q, dline_vld_d;

    logic [LINE_W-1:0] demand_line, fill_line, req_line;
    logic [MI_W-1:0]   fill_idx, alloc_idx;
    logic [CNT_W-1:0]  free_cnt, out_cnt;
    logic              fill_hit, dem_pend, pf_pend, dem_fill;
    logic              dem_miss, dem_req, pf_act, pf_skip, pf_req, accept;
    logic              unused_bits;

    assign demand_line = if_addr_i[ADDR_W-1:3];
    assign unused_bits = ^if_addr_i[2:0];

    // Entry lookup: fill match, pending-line matches, lowest free slot.
    always_comb begin
        fill_hit  = 1'b0;
        fill_idx  = '0;
        dem_pend  = 1'b0;
        pf_pend   = 1'b0;
        alloc_idx = '0;
        free_cnt  = '0;
        out_cnt   = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                alloc_idx = MI_W'(i);
                free_cnt  = free_cnt + CNT_W'(1);
            end else begin
                out_cnt = out_cnt + CNT_W'(1);
                if (mem_tag_i != '0 && mtag_q[i] == mem_tag_i) begin
                    fill_hit = 1'b1;
                    fill_idx = MI_W'(i);
                end
                if (line_q[i] == demand_line) dem_pend = 1'b1;
                if (line_q[i] == pf_line_q)   pf_pend  = 1'b1;
            end
        end
    end

    assign fill_line = line_q[fill_idx];
    assign dem_fill  = fill_hit && (fill_line == demand_line);

    // An entry freed by this cycle's fill is not counted as free until the
    // next cycle, so a full MSHR stays BUS_NONE through the fill cycle.
    assign dem_miss = !cache_hit_i && !dem_pend && !dem_fill && !if_flush_i;
    assign dem_req  = dem_miss && (free_cnt != '0);
    assign pf_act   = (pf_cnt_q < PFC_W'(PF_DEPTH));
    assign pf_skip  = pf_act && (cache_pf_hit_i || pf_pend);
    // One free entry is always held back for a demand miss.
    assign pf_req   = pf_act && !pf_skip && !dem_miss && (free_cnt >= CNT_W'(2));
    assign accept   = (dem_req || pf_req) && (mem_response_i != '0);
    assign req_line = dem_req ? demand_line : pf_line_q;

    // Next-state logic
    always_comb begin
        vld_d       = vld_q;
        line_d      = line_q;
        mtag_d      = mtag_q;
        pf_line_d   = pf_line_q;
        pf_cnt_d    = pf_cnt_q;
        dline_d     = dline_q;
        dline_vld_d = dline_vld_q;

        if (fill_hit) vld_d[fill_idx] = 1'b0;
        if (accept) begin
            vld_d[alloc_idx]  = 1'b1;
            line_d[alloc_idx] = req_line;
            mtag_d[alloc_idx] = mem_response_i;
        end

        if (if_flush_i) begin
            pf_cnt_d    = PFC_W'(PF_DEPTH);
            dline_vld_d = 1'b0;
        end else if (!dline_vld_q || demand_line != dline_q) begin
            dline_d     = demand_line;
            dline_vld_d = 1'b1;
            pf_line_d   = demand_line + LINE_W'(1);
            pf_cnt_d    = '0;
        end else if (pf_skip || (pf_req && accept)) begin
            pf_line_d = pf_line_q + LINE_W'(1);
            pf_cnt_d  = pf_cnt_q + PFC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            line_q      <= '0;
            mtag_q      <= '0;
            pf_line_q   <= '0;
            pf_cnt_q    <= PFC_W'(PF_DEPTH);
            dline_q     <= '0;
            dline_vld_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            line_q      <= line_d;
            mtag_q      <= mtag_d;
            pf_line_q   <= pf_line_d;
            pf_cnt_q    <= pf_cnt_d;
            dline_q     <= dline_d;
            dline_vld_q <= dline_vld_d;
        end
    end

    // Outputs, all forced low while reset is asserted.
    always_comb begin
        pf_probe_addr_o = '0;
        mem_addr_o      = '0;
        mem_command_o   = BUS_NONE;
        wr_en_o         = 1'b0;
        wr_idx_o        = '0;
        wr_tag_o        = '0;
        if_vld_o        = 1'b0;
        if_data_o       = '0;
        outstanding_o   = '0;
        if (rst) begin
            if (PF_DEPTH != 0) pf_probe_addr_o = {pf_line_q, 3'b000};
            if (dem_req || pf_req) begin
                mem_command_o = BUS_LOAD;
                mem_addr_o    = {req_line, 3'b000};
            end
            wr_en_o       = fill_hit;
            wr_idx_o      = fill_hit ? fill_line[IDX_W-1:0] : '0;
            wr_tag_o      = fill_hit ? fill_line[LINE_W-1:IDX_W] : '0;
            if_vld_o      = !if_flush_i && (cache_hit_i || dem_fill);
            if_data_o     = cache_hit_i ? cache_data_i : mem_data_i;
            outstanding_o = out_cnt;
        end
    end

endmodule

// File: doc/icache_mshr_ctrl.md
# icache_mshr_ctrl

Parametrised non-blocking miss/prefetch controller for the instruction cache, successor to the single-request Icache control/prefetch pair. It sits between fetch (IF), the external cachemem array and the Imem bus. It tracks up to NUM_MSHR outstanding line loads by memory tag and runs a next-N-line prefetch stream of depth PF_DEPTH. It forwards fill data to fetch in the same cycle the fill arrives.

## Interface
Parameters:
- ADDR_W, 64, byte address width; line = 8 bytes, line address = addr[ADDR_W-1:3]
- IDX_W, 5, cache index width; tag width TAG_W = ADDR_W-3-IDX_W
- NUM_MSHR, 4, outstanding load entries (2..15)
- PF_DEPTH, 2, lines prefetched ahead of the demand line (0 disables prefetch)
- MEM_TAG_W, 4, Imem response/tag width; value 0 = no response / no tag

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- if_addr_i  in  ADDR_W  fetch PC
- if_flush_i  in  1  branch mispredict flush
- cache_hit_i  in  1  cachemem hit for if_addr_i (same cycle)
- cache_data_i  in  64  cachemem data for if_addr_i
- cache_pf_hit_i  in  1  cachemem hit for pf_probe_addr_o (same cycle)
- pf_probe_addr_o  out  ADDR_W  line-aligned prefetch probe address
- mem_response_i  in  MEM_TAG_W  request acceptance tag, 0 = rejected
- mem_tag_i  in  MEM_TAG_W  fill tag, 0 = no fill
- mem_data_i  in  64  fill data
- mem_addr_o  out  ADDR_W  line-aligned request address
- mem_command_o  out  2  BUS_NONE / BUS_LOAD
- wr_en_o, wr_idx_o (IDX_W), wr_tag_o (TAG_W)  out  cachemem write port
- if_vld_o  out  1  if_data_o valid for if_addr_i
- if_data_o  out  64  instruction line data
- outstanding_o  out  $clog2(NUM_MSHR+1)  count of valid MSHRs

## Operation
- MSHR entry: {valid, line_addr, mem_tag, is_pf}. Allocation takes the lowest free index, only when mem_command_o=BUS_LOAD and mem_response_i!=0 in the same cycle; mem_tag := mem_response_i.
- Fill: mem_tag_i!=0 and it matches a valid entry: wr_en_o=1, idx/tag from the entry line_addr, entry freed at the clock edge. An unmatched nonzero mem_tag_i is ignored (no write).
- Demand miss: cache_hit_i=0, no valid entry for the demand line, no fill of that line this cycle, and if_flush_i=0. The controller then drives BUS_LOAD to the demand line if any entry is free.
- Prefetch stream: registers pf_line and pf_cnt. When the demand line differs from the last registered demand line (or the demand-valid bit is 0), set pf_line := demand_line+1 and pf_cnt := 0 at the next edge.
  - While pf_cnt<PF_DEPTH, probe pf_line.
  - If cache_pf_hit_i=1, or an entry already holds pf_line: advance (pf_line+1, pf_cnt+1) with no request.
  - Otherwise issue BUS_LOAD, but only if there is no demand request this cycle and at least 2 entries are free (one is reserved for demand). Advance only on acceptance.
- Arbitration: one request per cycle; demand has priority over prefetch. A rejected request is re-evaluated next cycle.
- if_vld_o = ~if_flush_i & (cache_hit_i | fill of the demand line this cycle).
- if_data_o = cache_hit_i ? cache_data_i : mem_data_i.
- Flush: suppresses demand issue and if_vld_o that cycle. It sets pf_cnt := PF_DEPTH (stream idle) and clears demand-valid. In-flight entries are kept and still fill the cache.
- Line address arithmetic wraps modulo 2^(ADDR_W-3).

## Timing
- Reset (rst=0, asynchronous): all entries invalid, pf_cnt=PF_DEPTH, demand-valid=0, outstanding_o=0. While rst=0, all outputs are forced to 0 (mem_command_o=BUS_NONE, wr_en_o=0, if_vld_o=0). Reset in mid-operation drops all outstanding tags; late fills are then ignored as unmatched.
- A demand miss is issued combinationally in the same cycle it is detected; the entry is valid from the next cycle.
- Hit: if_vld_o is asserted in the same cycle, with zero latency.
- Fill: wr_en_o and the forwarded if_vld_o are asserted in the fill cycle. The entry becomes reusable from the next cycle, not in the same cycle.
- Fill and allocation in the same cycle are both allowed.
- First prefetch probe happens 1 cycle after a demand line change.
- MSHR full: mem_command_o=BUS_NONE until a fill frees an entry.
- PF_DEPTH=0: pf_probe_addr_o is held at 0 and no prefetch requests are issued.

## Test plan
- Reset, then cold miss at 0x1000, mem_response_i=3 → BUS_LOAD to 0x1000 in the same cycle. Fill with tag 3 after 10 cycles → wr_en_o=1 with idx/tag of 0x1000, if_vld_o=1, if_data_o=mem_data_i.
- PF_DEPTH=2 after a miss at 0x1000, memory always accepts → loads to 0x1008 and 0x1010 on consecutive free cycles, then idle; outstanding_o=3.
- NUM_MSHR=4 with 4 loads outstanding, new miss → BUS_NONE until a fill. The fill cycle still shows BUS_NONE; BUS_LOAD is issued the next cycle.
- Miss on a line already outstanding → no duplicate request. if_vld_o stays 0 until that line's fill, then pulses 1.
- if_flush_i during a miss → no request that cycle and the prefetch stream is idle. An outstanding fill still writes (wr_en_o=1) with if_vld_o=0.
- mem_response_i=0 on the demand request → the same request repeats next cycle. mem_tag_i=7 with no matching entry → wr_en_o=0.
